mtsp_pack_unpack_stream: RTL and testbench

Parametrised, handshaked pack/unpack unit for the MTSP load/store path. It sits between the memory read/write return and the EW1 write-back stage. It converts between LANES 32-bit lanes and packed 8- or 16-bit elements, with zero/sign extension on unpack and optional saturation on pack. Unpacks that produce more elements than LANES are streamed as multiple output beats under back-pressure.

---
 rtl/mtsp_pack_unpack_pkg.sv | 18 +
 rtl/mtsp_pack_element.sv | 39 +++
 rtl/mtsp_pack_unpack_stream.sv | 192 +++++++++++++++++++
 tb/tb_mtsp_pack_unpack_stream.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mtsp_pack_unpack_pkg.sv
// rtl/mtsp_pack_unpack_pkg.sv - shared types and helpers for the MTSP pack/unpack stream
// Purpose: opcode, element format and FSM state types, plus small helpers
//          used by mtsp_pack_unpack_stream and mtsp_pack_element.
// Ports:   none (package).
package mtsp_pack_unpack_pkg;

    typedef enum logic {OP_UNPACK = 1'b0, OP_PACK = 1'b1} op_t;
    typedef enum logic {FMT_BYTE = 1'b0, FMT_HALF = 1'b1} fmt_t;
    typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_BURST = 1'b1} state_t;

    // Every lane masked; wide enough for the largest LANES, sliced at use.
    localparam logic [15:0] MASK_ALLMASKED = '1;

    function automatic logic [2:0] elems_per_dword(input fmt_t fmt);
        return (fmt == FMT_HALF) ? 3'd2 : 3'd4;
    endfunction

endpackage

// File: rtl/mtsp_pack_element.sv
// rtl/mtsp_pack_element.sv - per-lane 32-bit to 8/16-bit reducer
// Purpose: reduce one 32-bit lane to an element by truncation, unsigned
//          saturation or signed saturation. Purely combinational.
// Ports:   i_din    32-bit source lane
//          i_fmt    FMT_BYTE (8-bit result) / FMT_HALF (16-bit result)
//          i_signed source is two's complement when saturating
//          i_sat    1 = saturate, 0 = truncate
//          o_dout   result; for bytes only o_dout[7:0] is meaningful
module mtsp_pack_element
    import mtsp_pack_unpack_pkg::*;
(
    input  logic [31:0] i_din,
    input  fmt_t        i_fmt,
    input  logic        i_signed,
    input  logic        i_sat,
    output logic [15:0] o_dout
);

    logic        [31:0] w_max_u;
    logic signed [31:0] w_max_s;
    logic signed [31:0] w_min_s;

    always_comb begin
        w_max_u = (i_fmt == FMT_HALF) ? 32'h0000_FFFF : 32'h0000_00FF;
        w_max_s = (i_fmt == FMT_HALF) ? 32'sh0000_7FFF : 32'sh0000_007F;
        w_min_s = (i_fmt == FMT_HALF) ? 32'shFFFF_8000 : 32'shFFFF_FF80;
        o_dout  = i_din[15:0];
        if (i_sat) begin
            if (!i_signed) begin
                if (i_din > w_max_u) o_dout = w_max_u[15:0];
            end else if ($signed(i_din) > w_max_s) begin
                o_dout = w_max_s[15:0];
            end else if ($signed(i_din) < w_min_s) begin
                o_dout = w_min_s[15:0];
            end
        end
    end

endmodule

// File: rtl/mtsp_pack_unpack_stream.sv
// rtl/mtsp_pack_unpack_stream.sv - handshaked pack/unpack unit for the MTSP load/store path
// Purpose: UNPACK splits dwords into 8/16-bit elements, zero/sign-extends each to
//          32 bits and streams them as one or more beats; PACK reduces each lane
//          to an element and packs them into the leading dwords in one beat.
// Ports:   i_clk, i_rst (synchronous, active-high)
//          i_in_valid/o_in_ready request handshake; i_in_op, i_in_fmt, i_in_signed,
//          i_in_sat, i_in_count, i_in_data request fields (lane 0 = MSB slice)
//          o_out_valid/i_out_ready beat handshake; o_out_mask (bit LANES-1-i = lane i
//          masked), o_out_last, o_out_data beat fields; all outputs registered
module mtsp_pack_unpack_stream
    import mtsp_pack_unpack_pkg::*;
#(
    parameter int LANES = 4,
    parameter int DW    = 32
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_in_valid,
    output logic                     o_in_ready,
    input  logic                     i_in_op,
    input  logic                     i_in_fmt,
    input  logic                     i_in_signed,
    input  logic                     i_in_sat,
    input  logic [$clog2(LANES)-1:0] i_in_count,
    input  logic [LANES*DW-1:0]      i_in_data,
    output logic                     o_out_valid,
    input  logic                     i_out_ready,
    output logic [LANES-1:0]         o_out_mask,
    output logic                     o_out_last,
    output logic [LANES*DW-1:0]      o_out_data
);

    localparam int CW = $clog2(LANES);
    localparam int IW = CW + 2;   // element index within a request (at most 4 beats)
    localparam int NW = CW + 3;   // element count, up to 4*LANES inclusive

    state_t              r_state;
    logic [1:0]          r_beat;
    logic [LANES*DW-1:0] r_src;
    fmt_t                r_fmt;
    logic                r_signed;
    logic [CW-1:0]       r_count;
    logic                r_out_valid;
    logic                r_out_last;
    logic [LANES-1:0]    r_out_mask;
    logic [LANES*DW-1:0] r_out_data;

    logic w_slot_free;
    logic w_accept;
    logic w_is_pack;

    assign w_slot_free = !r_out_valid || i_out_ready;
    assign o_in_ready  = !i_rst && (r_state == ST_IDLE) && w_slot_free;
    assign w_accept    = i_in_valid && o_in_ready;
    assign w_is_pack   = (op_t'(i_in_op) == OP_PACK);

    // One beat generator serves both the first beat (live inputs) and the
    // following burst beats (captured request).
    logic [LANES*DW-1:0] w_g_src;
    fmt_t                w_g_fmt;
    logic                w_g_signed;
    logic [CW-1:0]       w_g_count;
    logic [1:0]          w_g_beat;
    logic [NW-1:0]       w_n;
    logic [2:0]          w_last_beat;
    logic                w_g_last;

    assign w_g_src     = (r_state == ST_IDLE) ? i_in_data : r_src;
    assign w_g_fmt     = (r_state == ST_IDLE) ? fmt_t'(i_in_fmt) : r_fmt;
    assign w_g_signed  = (r_state == ST_IDLE) ? i_in_signed : r_signed;
    assign w_g_count   = (r_state == ST_IDLE) ? i_in_count : r_count;
    assign w_g_beat    = (r_state == ST_IDLE) ? 2'd0 : r_beat + 2'd1;
    assign w_n         = (NW'(w_g_count) + NW'(1)) << ((w_g_fmt == FMT_HALF) ? 1 : 2);
    assign w_last_beat = 3'((w_n - NW'(1)) >> CW);
    assign w_g_last    = ({1'b0, w_g_beat} == w_last_beat);

    logic [DW-1:0]       w_src_dw [LANES];
    logic [15:0]         w_red    [LANES];
    logic [LANES*DW-1:0] w_unpack_data;
    logic [LANES-1:0]    w_unpack_mask;
    logic [LANES*DW-1:0] w_pack_data;
    logic [LANES-1:0]    w_pack_mask;

    for (genvar j = 0; j < LANES; j++) begin : g_lane
        logic [IW-1:0] w_idx;
        logic [CW-1:0] w_dsel;
        logic [1:0]    w_sub;
        logic [DW-1:0] w_dw;
        logic [7:0]    w_b;
        logic [15:0]   w_h;
        logic [DW-1:0] w_ext;
        logic          w_umask;

        assign w_src_dw[j] = w_g_src[(LANES-j)*DW-1 -: DW];

        // Element index = beat*LANES + lane; split into source dword and
        // position inside it (position 0 is the most significant element).
        assign w_idx   = {w_g_beat, CW'(j)};
        assign w_dsel  = (w_g_fmt == FMT_HALF) ? w_idx[CW:1] : w_idx[CW+1:2];
        assign w_sub   = (w_g_fmt == FMT_HALF) ? {1'b0, w_idx[0]} : w_idx[1:0];
        assign w_dw    = w_src_dw[w_dsel];
        assign w_b     = 8'(w_dw >> (5'd24 - {w_sub, 3'b000}));
        assign w_h     = 16'(w_dw >> (w_sub[0] ? 5'd0 : 5'd16));
        assign w_ext   = (w_g_fmt == FMT_HALF)
                       ? {{16{w_g_signed & w_h[15]}}, w_h}
                       : {{24{w_g_signed & w_b[7]}}, w_b};
        assign w_umask = ({1'b0, w_idx} >= w_n);

        assign w_unpack_data[(LANES-j)*DW-1 -: DW] = w_umask ? '0 : w_ext;
        assign w_unpack_mask[LANES-1-j]            = w_umask;

        mtsp_pack_element u_elem (
            .i_din    (i_in_data[(LANES-j)*DW-1 -: DW]),
            .i_fmt    (fmt_t'(i_in_fmt)),
            .i_signed (i_in_signed),
            .i_sat    (i_in_sat),
            .o_dout   (w_red[j])
        );

        // Packed result fills the first LANES/E dwords only.
        assign w_pack_mask[LANES-1-j] =
            (32'(j) * 32'(elems_per_dword(fmt_t'(i_in_fmt))) >= 32'(LANES));
    end

    always_comb begin
        w_pack_data = '0;
        for (int j = 0; j < LANES; j++) begin
            if (fmt_t'(i_in_fmt) == FMT_HALF)
                w_pack_data[LANES*DW-1-16*j -: 16] = w_red[j];
            else
                w_pack_data[LANES*DW-1-8*j -: 8] = w_red[j][7:0];
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= ST_IDLE;
            r_beat      <= 2'd0;
            r_src       <= '0;
            r_fmt       <= FMT_BYTE;
            r_signed    <= 1'b0;
            r_count     <= '0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_out_mask  <= MASK_ALLMASKED[LANES-1:0];
            r_out_data  <= '0;
        end else begin
            if (r_out_valid && i_out_ready) r_out_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_out_valid <= 1'b1;
                        if (w_is_pack) begin
                            r_out_data <= w_pack_data;
                            r_out_mask <= w_pack_mask;
                            r_out_last <= 1'b1;
                        end else begin
                            r_out_data <= w_unpack_data;
                            r_out_mask <= w_unpack_mask;
                            r_out_last <= w_g_last;
                            r_beat     <= 2'd0;
                            if (!w_g_last) begin
                                r_state  <= ST_BURST;
                                r_src    <= i_in_data;
                                r_fmt    <= fmt_t'(i_in_fmt);
                                r_signed <= i_in_signed;
                                r_count  <= i_in_count;
                            end
                        end
                    end
                end
                ST_BURST: begin
                    if (w_slot_free) begin
                        r_out_valid <= 1'b1;
                        r_out_data  <= w_unpack_data;
                        r_out_mask  <= w_unpack_mask;
                        r_out_last  <= w_g_last;
                        r_beat      <= w_g_last ? 2'd0 : w_g_beat;
                        if (w_g_last) r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign o_out_valid = r_out_valid;
    assign o_out_last  = r_out_last;
    assign o_out_mask  = r_out_mask;
    assign o_out_data  = r_out_data;

endmodule

// File: tb/tb_mtsp_pack_unpack_stream.sv
// tb/tb_mtsp_pack_unpack_stream.sv - self-checking bench for mtsp_pack_unpack_stream
module tb_mtsp_pack_unpack_stream;

    localparam int LANES = 4;
    localparam int DW    = 32;
    localparam int W     = LANES * DW;

    logic             clk = 1'b0;
    logic             i_rst;
    logic             i_in_valid;
    logic             o_in_ready;
    logic             i_in_op;
    logic             i_in_fmt;
    logic             i_in_signed;
    logic             i_in_sat;
    logic [1:0]       i_in_count;
    logic [W-1:0]     i_in_data;
    logic             o_out_valid;
    logic             i_out_ready;
    logic [LANES-1:0] o_out_mask;
    logic             o_out_last;
    logic [W-1:0]     o_out_data;

    always #5 clk = ~clk;

    mtsp_pack_unpack_stream #(.LANES(LANES), .DW(DW)) dut (
        .i_clk       (clk),
        .i_rst       (i_rst),
        .i_in_valid  (i_in_valid),
        .o_in_ready  (o_in_ready),
        .i_in_op     (i_in_op),
        .i_in_fmt    (i_in_fmt),
        .i_in_signed (i_in_signed),
        .i_in_sat    (i_in_sat),
        .i_in_count  (i_in_count),
        .i_in_data   (i_in_data),
        .o_out_valid (o_out_valid),
        .i_out_ready (i_out_ready),
        .o_out_mask  (o_out_mask),
        .o_out_last  (o_out_last),
        .o_out_data  (o_out_data)
    );

    int n_checks = 0;
    int n_errors = 0;

    logic [W-1:0]     exp_data [4];
    logic [LANES-1:0] exp_mask [4];
    logic             exp_last [4];
    int               exp_n;
    logic [W-1:0]     cap_data [4];
    logic [LANES-1:0] cap_mask [4];

    task automatic chkw(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chkm(input string tag, input logic [LANES-1:0] obs, input logic [LANES-1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Reference model: element list built arithmetically, then chunked into beats.
    task automatic build_expected(input bit op, input bit fmt, input bit sgn, input bit sat,
                                  input logic [1:0] count, input logic [W-1:0] data);
        int          ew, e, used;
        logic [31:0] elems[$];
        logic [31:0] dw;
        longint      u, v, lo, hi, m;
        ew = fmt ? 16 : 8;
        e  = 32 / ew;
        m  = (longint'(1) << ew) - 1;
        for (int b = 0; b < 4; b++) begin
            exp_data[b] = '0;
            exp_mask[b] = '1;
            exp_last[b] = 1'b0;
        end
        if (!op) begin
            for (int d = 0; d <= int'(count); d++) begin
                dw = data[W-1-32*d -: 32];
                for (int s = 0; s < e; s++) begin
                    u = (longint'(dw) >> (32 - ew*(s+1))) & m;
                    if (sgn && u >= (longint'(1) << (ew-1))) u = u - (longint'(1) << ew);
                    elems.push_back(u[31:0]);
                end
            end
            exp_n = (elems.size() + LANES - 1) / LANES;
            for (int k = 0; k < elems.size(); k++) begin
                exp_data[k/LANES][W-1-32*(k%LANES) -: 32] = elems[k];
                exp_mask[k/LANES][LANES-1-(k%LANES)]      = 1'b0;
            end
            exp_last[exp_n-1] = 1'b1;
        end else begin
            exp_n       = 1;
            exp_last[0] = 1'b1;
            used        = LANES * ew / 32;
            for (int i = 0; i < LANES; i++) begin
                dw = data[W-1-32*i -: 32];
                v  = sgn ? longint'($signed(dw)) : longint'(dw);
                if (sat) begin
                    if (sgn) begin
                        lo = -(longint'(1) << (ew-1));
                        hi = (longint'(1) << (ew-1)) - 1;
                    end else begin
                        lo = 0;
                        hi = m;
                    end
                    if (v > hi) v = hi;
                    if (v < lo) v = lo;
                end
                v = v & m;
                exp_data[0] = exp_data[0] | (W'(v) << (W - ew*(i+1)));
                exp_mask[0][LANES-1-i] = (i >= used);
            end
        end
    endtask

    // Issues one request and drains its beats, checking every observed cycle.
    task automatic run_req(input bit op, input bit fmt, input bit sgn, input bit sat,
                           input logic [1:0] count, input logic [W-1:0] data,
                           input bit rnd_ready, input int stall_beat, input int stall_n,
                           input int rst_beat, input string tag);
        int waited, stalls, k, budget;
        bit rdy;
        build_expected(op, fmt, sgn, sat, count, data);
        i_in_valid  = 1'b1;
        i_in_op     = op;
        i_in_fmt    = fmt;
        i_in_signed = sgn;
        i_in_sat    = sat;
        i_in_count  = count;
        i_in_data   = data;
        waited      = 0;
        #1;
        while (!o_in_ready && waited < 50) begin
            @(negedge clk);
            #1;
            waited++;
        end
        chk1({tag, " accept"}, o_in_ready, 1'b1);
        if (!o_in_ready) begin
            i_in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        @(negedge clk);
        // Fields are only sampled at accept; scramble them afterwards.
        i_in_valid  = 1'b0;
        i_in_count  = 2'($urandom);
        i_in_fmt    = 1'($urandom);
        i_in_signed = 1'($urandom);
        i_in_data   = {$urandom, $urandom, $urandom, $urandom};
        k      = 0;
        stalls = 0;
        budget = 0;
        while (k < exp_n && budget < 200) begin
            budget++;
            chk1({tag, " valid"}, o_out_valid, 1'b1);
            if (!o_out_valid) break;
            chkw({tag, " data"}, o_out_data, exp_data[k]);
            chkm({tag, " mask"}, o_out_mask, exp_mask[k]);
            chk1({tag, " last"}, o_out_last, exp_last[k]);
            if (k == rst_beat) begin
                i_rst = 1'b1;
                return;
            end
            if (k == stall_beat && stalls < stall_n) begin
                rdy = 1'b0;
                stalls++;
            end else begin
                rdy = rnd_ready ? ($urandom_range(0, 2) != 0) : 1'b1;
            end
            i_out_ready = rdy;
            #1;
            chk1({tag, " in_ready"}, o_in_ready, (k == exp_n-1) ? rdy : 1'b0);
            if (rdy) begin
                cap_data[k] = o_out_data;
                cap_mask[k] = o_out_mask;
                k++;
            end
            if (k < exp_n) @(negedge clk);
        end
        chk1({tag, " all beats"}, (k == exp_n), 1'b1);
    endtask

    function automatic logic [31:0] rnd_lane();
        case ($urandom_range(0, 2))
            0:       return $urandom;
            1:       return 32'($urandom_range(0, 700)) - 32'd350;
            default: return 32'($urandom_range(0, 70000)) - 32'd35000;
        endcase
    endfunction

    logic [W-1:0] seq4;
    logic [W-1:0] pk;

    initial begin
        i_rst       = 1'b1;
        i_in_valid  = 1'b0;
        i_in_op     = 1'b0;
        i_in_fmt    = 1'b0;
        i_in_signed = 1'b0;
        i_in_sat    = 1'b0;
        i_in_count  = 2'd0;
        i_in_data   = '0;
        i_out_ready = 1'b1;
        seq4 = {32'h01020304, 32'h05060708, 32'h090A0B0C, 32'h0D0E0F10};
        pk   = {32'd300, 32'hFFFFFF38, 32'd5, 32'hFFFFFFFF};

        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        chk1("reset valid", o_out_valid, 1'b0);
        chk1("reset last", o_out_last, 1'b0);
        chkm("reset mask", o_out_mask, 4'b1111);
        chkw("reset data", o_out_data, '0);
        chk1("reset in_ready", o_in_ready, 1'b0);
        i_rst = 1'b0;

        run_req(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, {32'h80FF0102, 96'h0}, 1'b0, -1, 0, -1, "unp_b");
        chkw("unp_b lanes", cap_data[0], {32'h80, 32'hFF, 32'h01, 32'h02});
        chkm("unp_b mask", cap_mask[0], 4'b0000);

        run_req(1'b0, 1'b1, 1'b1, 1'b0, 2'd1, {32'h80007FFF, 32'h0001FFFF, 64'h0}, 1'b0, -1, 0, -1, "unp_h");
        chkw("unp_h lanes", cap_data[0], {32'hFFFF8000, 32'h00007FFF, 32'h00000001, 32'hFFFFFFFF});

        run_req(1'b0, 1'b0, 1'b0, 1'b0, 2'd3, seq4, 1'b0, -1, 0, -1, "unp4");
        chkw("unp4 beat2", cap_data[2], {32'h09, 32'h0A, 32'h0B, 32'h0C});

        run_req(1'b1, 1'b0, 1'b1, 1'b1, 2'd0, pk, 1'b0, -1, 0, -1, "pack_sat");
        chkw("pack_sat data", cap_data[0], {32'h7F8005FF, 96'h0});
        chkm("pack_sat mask", cap_mask[0], 4'b0111);

        run_req(1'b1, 1'b0, 1'b1, 1'b0, 2'd0, pk, 1'b0, -1, 0, -1, "pack_trunc");
        chkw("pack_trunc data", cap_data[0], {32'h2C3805FF, 96'h0});

        run_req(1'b0, 1'b0, 1'b0, 1'b0, 2'd3, seq4, 1'b0, 1, 3, -1, "bp");
        chkw("bp beat0", cap_data[0], {32'h01, 32'h02, 32'h03, 32'h04});
        chkw("bp beat1", cap_data[1], {32'h05, 32'h06, 32'h07, 32'h08});
        chkw("bp beat3", cap_data[3], {32'h0D, 32'h0E, 32'h0F, 32'h10});

        run_req(1'b0, 1'b0, 1'b0, 1'b0, 2'd3, seq4, 1'b0, -1, 0, 2, "rst_burst");
        @(posedge clk);
        @(negedge clk);
        chk1("rst_burst valid", o_out_valid, 1'b0);
        chkm("rst_burst mask", o_out_mask, 4'b1111);
        chkw("rst_burst data", o_out_data, '0);
        chk1("rst_burst in_ready", o_in_ready, 1'b0);
        i_rst = 1'b0;
        run_req(1'b1, 1'b1, 1'b0, 1'b1, 2'd0, {32'h00012345, 32'h0000BEEF, 32'h7, 32'hFFFFFFFF}, 1'b0, -1, 0, -1, "post_rst");
        chkw("post_rst data", cap_data[0], {32'hFFFFBEEF, 32'h0007FFFF, 64'h0});

        for (int t = 0; t < 60; t++) begin
            run_req(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 2'($urandom),
                    {rnd_lane(), rnd_lane(), rnd_lane(), rnd_lane()}, 1'b1, -1, 0, -1, "rand");
        end

        @(negedge clk);
        i_out_ready = 1'b1;
        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
